// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM encodings,
// default vectors, instruction width and the fetched-entry record.
package fetch_defs;

  localparam int INSTR_W = 32;

  localparam logic [31:0] RESET_VEC_D = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_D   = 32'h8000_0180;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_BLOCK = 2'd3;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_ent_t;

  // Sequential next PC; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a word that returns while decode is
// stalled. Flush wins over load; load wins over drain.
module fetch_skid
  import fetch_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       drain,
  input  logic       flush,
  input  fetch_ent_t din,
  output logic       vld,
  output fetch_ent_t dout
);

  // Entry state: reset/flush empty, load captures, drain releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      vld  <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage sequencer: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, with a one-entry skid for stalled returns.
module fetch_pc_ctrl
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_D,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  input  logic               exc_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  logic [1:0]  state;
  logic [31:0] pc, req_addr;
  logic        redir;
  logic [31:0] tgt;
  logic        deliver, to_out, to_skid, skid_drain;
  logic        skid_vld;
  fetch_ent_t  skid_q, rsp;

  assign redir = exc_req | br_taken;
  assign tgt   = exc_req ? EXC_VEC : {br_target[31:2], 2'b00};

  // Request is held through S_DROP so an outstanding access is never dropped.
  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr = req_addr;

  assign rsp        = '{pc: req_addr, instr: imem_rdata};
  assign deliver    = (state == S_REQ) && imem_ack && !redir;
  assign to_out     = deliver && (!if_valid || !stall) && !skid_vld;
  assign to_skid    = deliver && !to_out;
  assign skid_drain = skid_vld && !stall && !redir;

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (to_skid),
    .drain (skid_drain),
    .flush (redir),
    .din   (rsp),
    .vld   (skid_vld),
    .dout  (skid_q)
  );

  // Fetch FSM and next-PC selection (exception > branch > sequential).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_VEC;
      req_addr <= RESET_VEC;
    end else begin
      case (state)
        S_IDLE: begin
          pc       <= redir ? tgt : pc;
          req_addr <= redir ? tgt : pc;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (imem_ack && redir) begin
            pc       <= tgt;
            req_addr <= tgt;
          end else if (imem_ack) begin
            pc       <= pc_inc(pc);
            req_addr <= pc_inc(pc);
            if (to_skid) state <= S_BLOCK;
          end else if (redir) begin
            pc    <= tgt;
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (redir) pc <= tgt;
          if (imem_ack) begin
            req_addr <= redir ? tgt : pc;
            state    <= S_REQ;
          end
        end
        S_BLOCK: begin
          if (redir) begin
            pc       <= tgt;
            req_addr <= tgt;
            state    <= S_REQ;
          end else if (!stall) begin
            req_addr <= pc;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID register: redirect squashes; otherwise skid first, then fresh word.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (redir) begin
      if_valid <= 1'b0;
    end else if (skid_vld && !stall) begin
      if_valid <= 1'b1;
      if_pc    <= skid_q.pc;
      if_instr <= skid_q.instr;
    end else if (to_out) begin
      if_valid <= 1'b1;
      if_pc    <= rsp.pc;
      if_instr <= rsp.instr;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a delivery scoreboard.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, exc_req, imem_ack;
  logic [31:0] br_target, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  logic        prev_v = 1'b0;
  logic [31:0] prev_pc = '0;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge and score any newly presented word.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (if_valid && (!prev_v || if_pc != prev_pc)) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_extra: observed pc %h expected no word", if_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e[63:32]);
        chk("sb_instr", if_instr, e[31:0]);
      end
    end
    prev_v  = if_valid;
    prev_pc = if_pc;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; br_taken = 1'b0; exc_req = 1'b0; stall = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'hBFC0_0000);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    sb.delete();
    rst = 1'b0;
    tick();
  endtask

  // Memory answers the current request this cycle with ~addr.
  task automatic fetch_ack(input logic [31:0] a);
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", imem_addr, a);
    imem_ack = 1'b1;
    imem_rdata = ~a;
    sb.push_back({a, ~a});
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    br_target = '0; imem_rdata = '0;

    // Reset then back-to-back sequential fetch
    do_reset();
    fetch_ack(32'hBFC0_0000);
    chk("seq_valid0", 32'(if_valid), 32'd1);
    fetch_ack(32'hBFC0_0004);
    chk("seq_valid1", 32'(if_valid), 32'd1);
    fetch_ack(32'hBFC0_0008);
    chk("seq_valid2", 32'(if_valid), 32'd1);

    // Wait-state memory: request and address held while unacked
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", 32'(imem_req), 32'd1);
      chk("ws_addr", imem_addr, 32'hBFC0_0000);
      chk("ws_valid", 32'(if_valid), 32'd0);
      tick();
    end
    fetch_ack(32'hBFC0_0000);

    // Stall while next word returns: it parks in the skid
    stall = 1'b1;
    fetch_ack(32'hBFC0_0004);
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", if_pc, 32'hBFC0_0000);
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("block_req", 32'(imem_req), 32'd0);
      tick();
    end
    chk("block_req_last", 32'(imem_req), 32'd0);
    stall = 1'b0;
    tick();
    chk("drain_pc", if_pc, 32'hBFC0_0004);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", imem_addr, 32'hBFC0_0008);

    // Branch while BFC00008 is outstanding
    br_taken = 1'b1; br_target = 32'h0040_0102;
    tick();
    br_taken = 1'b0;
    chk("br_valid", 32'(if_valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'hBFC0_0008);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("drop_discard", 32'(if_valid), 32'd0);
    fetch_ack(32'h0040_0100);

    // Exception + branch + stall together: exception wins, stall ignored
    exc_req = 1'b1; br_taken = 1'b1; br_target = 32'h0000_1230; stall = 1'b1;
    tick();
    exc_req = 1'b0; br_taken = 1'b0; stall = 1'b0;
    chk("exc_valid", 32'(if_valid), 32'd0);
    chk("exc_old_addr", imem_addr, 32'h0040_0104);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem_ack = 1'b0;
    chk("exc_discard", 32'(if_valid), 32'd0);
    fetch_ack(32'h8000_0180);

    // Redirect coincident with ack, to the top word; then wrap to 0
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    br_taken = 1'b0; imem_ack = 1'b0;
    chk("ackbr_valid", 32'(if_valid), 32'd0);
    fetch_ack(32'hFFFF_FFFC);
    fetch_ack(32'h0000_0000);

    // Reset during S_DROP; a late ack under reset is ignored
    br_taken = 1'b1; br_target = 32'h0000_1000;
    tick();
    br_taken = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'h0000_0004);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'hBFC0_0000);
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    chk("late_ack_req", 32'(imem_req), 32'd0);
    chk("late_ack_valid", 32'(if_valid), 32'd0);
    imem_ack = 1'b0; rst = 1'b0;
    tick();
    fetch_ack(32'hBFC0_0000);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
